// File: rtl/altr_hps_rst_seq_pkg.sv
// Shared types for the HPS reset request sequencer.
// State encodings and the counter-width helper.
package altr_hps_rst_seq_pkg;

  typedef enum logic [2:0] {
    POR_HOLD = 3'd0,
    IDLE     = 3'd1,
    QUIESCE  = 3'd2,
    ASSERT   = 3'd3,
    DONE     = 3'd4
  } rst_seq_state_t;

  localparam int CYC_MIN = 1;
  localparam int CYC_MAX = 2046;

  // Bits needed to hold value v, never less than 1.
  function automatic int cnt_width(input int v);
    int w;
    w = 1;
    while (w < 31 && (v >> w) != 0)
      w++;
    return w;
  endfunction

endpackage

// File: rtl/altr_hps_sat_cntr.sv
// Saturating up-counter: sync clear, enable, terminal compare.
// Ports: clk, rst_n (async low), clr, en, term -> hit.
module altr_hps_sat_cntr
  import altr_hps_rst_seq_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             hit
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != {WIDTH{1'b1}})
      cnt <= cnt + WIDTH'(1);
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/altr_hps_rst_req_seq.sv
// Reset request sequencer: quiesce, timed reset pulse, ack.
// Ports: clk, i_rst_n, rst_req/rst_ack, quiesce_req/quiesce_ack,
// o_rst_n, timeout_flag. Option: ALTR_HPS_RST_ACK_TIMEOUT_EN.
module altr_hps_rst_req_seq
  import altr_hps_rst_seq_pkg::*;
#(
  parameter int ASSERT_CYC  = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic rst_req,
  output logic rst_ack,
  output logic quiesce_req,
  input  logic quiesce_ack,
  output logic o_rst_n,
  output logic timeout_flag
);

`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
  localparam int MAX_TERM =
    (ASSERT_CYC > TIMEOUT_CYC) ? ASSERT_CYC : TIMEOUT_CYC;
`else
  localparam int MAX_TERM = ASSERT_CYC;
`endif
  localparam int CNT_WIDTH = cnt_width(MAX_TERM - 1);

  localparam logic [CNT_WIDTH-1:0] A_TERM =
    CNT_WIDTH'(ASSERT_CYC - 1);
`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] T_TERM =
    CNT_WIDTH'(TIMEOUT_CYC - 1);
`endif

  if (ASSERT_CYC < CYC_MIN || ASSERT_CYC > CYC_MAX ||
      TIMEOUT_CYC < CYC_MIN || TIMEOUT_CYC > CYC_MAX)
  begin : g_bad_param
    $fatal(1, "altr_hps_rst_req_seq: cycle parameter out of range");
  end

  rst_seq_state_t state_q, state_d;
  logic rst_n_q, rst_n_d;
  logic qreq_q, qreq_d;
  logic ack_q, ack_d;
  logic cnt_clr, cnt_en, cnt_hit;
  logic [CNT_WIDTH-1:0] term;
`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
  logic tflag_q, tflag_d;
`endif

  altr_hps_sat_cntr #(
    .WIDTH (CNT_WIDTH)
  ) u_cntr (
    .clk   (clk),
    .rst_n (i_rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (term),
    .hit   (cnt_hit)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= POR_HOLD;
      rst_n_q <= 1'b0;
      qreq_q  <= 1'b0;
      ack_q   <= 1'b0;
`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
      tflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rst_n_q <= rst_n_d;
      qreq_q  <= qreq_d;
      ack_q   <= ack_d;
`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
      tflag_q <= tflag_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rst_n_d = rst_n_q;
    qreq_d  = qreq_q;
    ack_d   = ack_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    term    = A_TERM;
`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
    tflag_d = tflag_q;
`endif
    unique case (state_q)
      POR_HOLD: begin
        cnt_en = 1'b1;
        if (cnt_hit) begin
          state_d = IDLE;
          rst_n_d = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      IDLE: begin
        if (rst_req) begin
          state_d = QUIESCE;
          qreq_d  = 1'b1;
          cnt_clr = 1'b1;
`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
          tflag_d = 1'b0;
`endif
        end
      end
      QUIESCE: begin
`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
        cnt_en = 1'b1;
        term   = T_TERM;
`endif
        if (quiesce_ack) begin
          state_d = ASSERT;
          rst_n_d = 1'b0;
          cnt_clr = 1'b1;
        end
`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
        // A late ack on the terminal edge still counts as clean.
        else if (cnt_hit) begin
          state_d = ASSERT;
          rst_n_d = 1'b0;
          cnt_clr = 1'b1;
          tflag_d = 1'b1;
        end
`endif
      end
      ASSERT: begin
        cnt_en = 1'b1;
        if (cnt_hit) begin
          state_d = DONE;
          rst_n_d = 1'b1;
          qreq_d  = 1'b0;
          ack_d   = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      DONE: begin
        if (!rst_req) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: state_d = POR_HOLD;
    endcase
  end

  assign o_rst_n     = rst_n_q;
  assign quiesce_req = qreq_q;
  assign rst_ack     = ack_q;
`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
  assign timeout_flag = tflag_q;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_altr_hps_rst_req_seq.sv
// Bench for altr_hps_rst_req_seq (ASSERT_CYC=4, TIMEOUT_CYC=10).
// Expected outputs queued per edge, compared 1 ns after it.
module tb_altr_hps_rst_req_seq;

  localparam int AC = 4;
  localparam int TC = 10;
`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
  localparam int DLY = 5;
`else
  localparam int DLY = 20;
`endif

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic i_rst_n;
  logic rst_req;
  logic quiesce_ack;
  logic rst_ack;
  logic quiesce_req;
  logic o_rst_n;
  logic timeout_flag;
  logic [3:0] obs;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  altr_hps_rst_req_seq #(
    .ASSERT_CYC  (AC),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .rst_req      (rst_req),
    .rst_ack      (rst_ack),
    .quiesce_req  (quiesce_req),
    .quiesce_ack  (quiesce_ack),
    .o_rst_n      (o_rst_n),
    .timeout_flag (timeout_flag)
  );

  // {o_rst_n, quiesce_req, rst_ack, timeout_flag}
  assign obs = {o_rst_n, quiesce_req, rst_ack, timeout_flag};

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs, e.exp);
    end
  end

  // Drive at a negedge, queue the state expected after the next edge.
  task automatic cyc(input logic rq, input logic qa,
                     input logic [3:0] exp, input string tag);
    exp_t e;
    rst_req     = rq;
    quiesce_ack = qa;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rq, input logic qa,
                     input logic [3:0] exp, input string tag);
    for (int i = 0; i < n; i++)
      cyc(rq, qa, exp, tag);
  endtask

  task automatic por(input string tag);
    run(AC - 1, 1'b0, 1'b0, 4'b0000, {tag, "_hold"});
    cyc(1'b0, 1'b0, 4'b1000, {tag, "_rel"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    i_rst_n     = 1'b0;
    rst_req     = 1'b0;
    quiesce_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vals", obs, 4'b0000);
    i_rst_n = 1'b1;
    por("por");
    run(2, 1'b0, 1'b0, 4'b1000, "idle");

    // Ack already high: minimum latency.
    cyc(1'b1, 1'b1, 4'b1100, "fast_req");
    run(AC, 1'b1, 1'b1, 4'b0100, "fast_pulse");
    cyc(1'b1, 1'b1, 4'b1010, "fast_ack");
    cyc(1'b1, 1'b1, 4'b1010, "fast_hold");
    cyc(1'b0, 1'b1, 4'b1000, "fast_drop");
    cyc(1'b0, 1'b0, 4'b1000, "fast_idle");

    // Delayed quiesce ack.
    cyc(1'b1, 1'b0, 4'b1100, "dly_req");
    run(DLY - 1, 1'b1, 1'b0, 4'b1100, "dly_wait");
    cyc(1'b1, 1'b1, 4'b0100, "dly_ackedge");
    run(AC - 1, 1'b1, 1'b0, 4'b0100, "dly_pulse");
    cyc(1'b1, 1'b0, 4'b1010, "dly_ack");
    cyc(1'b0, 1'b0, 4'b1000, "dly_drop");

    // Request dropped while quiescing.
    cyc(1'b1, 1'b0, 4'b1100, "abort_req");
    run(2, 1'b0, 1'b0, 4'b1100, "abort_wait");
    cyc(1'b0, 1'b1, 4'b0100, "abort_ackedge");
    run(AC - 1, 1'b0, 1'b0, 4'b0100, "abort_pulse");
    cyc(1'b0, 1'b0, 4'b1010, "abort_ack");
    cyc(1'b0, 1'b0, 4'b1000, "abort_ack1");
    cyc(1'b0, 1'b0, 4'b1000, "abort_idle");

`ifdef ALTR_HPS_RST_ACK_TIMEOUT_EN
    // Ack never arrives: forced at edge TC after request.
    cyc(1'b1, 1'b0, 4'b1100, "to_req");
    run(TC - 1, 1'b1, 1'b0, 4'b1100, "to_wait");
    cyc(1'b1, 1'b0, 4'b0101, "to_force");
    run(AC - 1, 1'b1, 1'b0, 4'b0101, "to_pulse");
    cyc(1'b1, 1'b0, 4'b1011, "to_ack");
    cyc(1'b0, 1'b0, 4'b1001, "to_sticky");
    run(2, 1'b0, 1'b0, 4'b1001, "to_idle");
    // Next request clears flag; ack on terminal edge wins.
    cyc(1'b1, 1'b0, 4'b1100, "tie_req");
    run(TC - 1, 1'b1, 1'b0, 4'b1100, "tie_wait");
    cyc(1'b1, 1'b1, 4'b0100, "tie_ackedge");
    run(AC - 1, 1'b1, 1'b0, 4'b0100, "tie_pulse");
    cyc(1'b0, 1'b0, 4'b1010, "tie_ack");
    cyc(1'b0, 1'b0, 4'b1000, "tie_drop");
`endif

    // Reset pulsed in the middle of ASSERT.
    cyc(1'b1, 1'b1, 4'b1100, "mid_req");
    run(2, 1'b1, 1'b1, 4'b0100, "mid_pulse");
    i_rst_n = 1'b0;
    #1;
    chk("mid_reset", obs, 4'b0000);
    rst_req     = 1'b0;
    quiesce_ack = 1'b0;
    @(negedge clk);
    chk("mid_reset_hold", obs, 4'b0000);
    i_rst_n = 1'b1;
    por("por2");
    cyc(1'b1, 1'b1, 4'b1100, "post_req");
    run(AC, 1'b1, 1'b1, 4'b0100, "post_pulse");
    cyc(1'b0, 1'b0, 4'b1010, "post_ack");
    cyc(1'b0, 1'b0, 4'b1000, "post_drop");

    chk("sb_drain", 4'(sb.size()), 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
